// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with device acknowledge check
// Ports: clk/rst (synchronous, active-high); ps2_clk/ps2_data open-drain lines, driven 0 or z;
//   tx_data/tx_valid/tx_ready single-byte handshake; tx_done/tx_err one-cycle result pulses;
//   busy high outside IDLE. Define PS2_TX_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy
);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, INHIBIT, SEND, WAIT_IDLE} state_t;
   state_t state;
   logic [1:0] clk_sync, data_sync;
   logic clk_s, data_s, clk_p, fe, clk_oe, data_oe, err;
   logic [8:0] sh;
   logic [3:0] bitcnt;
   logic [IW-1:0] cnt;
`ifdef PS2_TX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd;
`endif
   assign ps2_clk = clk_oe ? 1'b0 : 1'bz;
   assign ps2_data = data_oe ? 1'b0 : 1'bz;
   assign clk_s = clk_sync[1];
   assign data_s = data_sync[1];
   assign fe = clk_p & ~clk_s;
   assign tx_ready = state == IDLE;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         clk_sync <= 2'b11;
         data_sync <= 2'b11;
         clk_p <= 1'b1;
         clk_oe <= 1'b0;
         data_oe <= 1'b0;
         err <= 1'b0;
         sh <= '0;
         bitcnt <= '0;
         cnt <= '0;
         tx_done <= 1'b0;
         tx_err <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd <= '0;
`endif
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_p <= clk_s;
         tx_done <= 1'b0;
         tx_err <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         // Held at zero outside SEND/WAIT_IDLE, so it starts from zero on entry to SEND.
         wd <= (fe || state == IDLE || state == INHIBIT) ? '0 : wd + 1'b1;
`endif
         case (state)
            IDLE: if (tx_valid) begin
               sh <= {~^tx_data, tx_data};
               err <= 1'b0;
               cnt <= '0;
               bitcnt <= '0;
               clk_oe <= 1'b1;
               state <= INHIBIT;
            end
            INHIBIT: begin
               cnt <= cnt + 1'b1;
               // Data goes low for the last inhibit cycle and stays low as the start bit.
               if (int'(cnt) + 2 >= INHIBIT_CYCLES) data_oe <= 1'b1;
               if (int'(cnt) + 1 == INHIBIT_CYCLES) begin
                  clk_oe <= 1'b0;
                  state <= SEND;
               end
            end
            SEND: if (fe) begin
               bitcnt <= bitcnt + 1'b1;
               // Edges 1-9 shift out data then parity; edges 10 and 11 leave data released.
               data_oe <= (bitcnt < 4'd9) & ~sh[0];
               sh <= sh >> 1;
               if (bitcnt == 4'd10) begin
                  err <= data_s;
                  state <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: if (clk_s && data_s) begin
               tx_done <= 1'b1;
               tx_err <= err;
               state <= IDLE;
            end
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         if ((state == SEND || state == WAIT_IDLE) && int'(wd) == TIMEOUT_CYCLES) begin
            clk_oe <= 1'b0;
            data_oe <= 1'b0;
            err <= 1'b1;
            tx_done <= 1'b1;
            tx_err <= 1'b1;
            state <= IDLE;
         end
`endif
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a clocking, acknowledging device model
module tb_ps2_host_tx;
   localparam int INH = 20, TMO = 300, HALF = 40;
   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         err;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic tx_valid = 1'b0;
   logic tx_ready, tx_done, tx_err, busy;
   logic dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
   wire ps2_clk, ps2_data;
   int nvec = 0, nbad = 0;
   int done_cnt = 0, err_cnt = 0, long_cnt = 0, rdy_hi = 0;
   logic done_q = 1'b0;
   assign ps2_clk = dev_clk_lo ? 1'b0 : 1'bz;
   assign ps2_data = dev_dat_lo ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);
   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_done(tx_done), .tx_err(tx_err), .busy(busy)
   );
   always #5 clk = ~clk;
   always begin
      @(posedge clk);
      #1;
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if ((tx_done && done_q) || (tx_err && !tx_done)) long_cnt++;
      if (tx_ready) rdy_hi++;
      done_q = tx_done;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic dev_frame(input int nfe, input bit ack, output logic [10:0] rd, output bit ok);
      int i;
      i = 0;
      rd = '0;
      ok = 1'b0;
      while (i < 4 * INH + 200 && !(ps2_clk === 1'b1 && ps2_data === 1'b0)) begin
         @(negedge clk);
         i++;
      end
      if (i >= 4 * INH + 200) return;
      ok = 1'b1;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < nfe; k++) begin
         rd[k] = ps2_data;
         if (k == 10) dev_dat_lo = ack;
         dev_clk_lo = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_lo = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      dev_dat_lo = 1'b0;
   endtask
   task automatic wait_done(input int d0, input int lim, output int n);
      n = 0;
      while (done_cnt == d0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(done_cnt != d0), 1);
   endtask
   task automatic run_vec(input vec_t v);
      logic [10:0] rd;
      bit ok;
      int d0, e0, l0, lows, n;
      logic last_d;
      d0 = done_cnt;
      e0 = err_cnt;
      l0 = long_cnt;
      @(negedge clk);
      tx_data = v.data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = ~v.data;
      chk("busy_acc", 32'(busy), 1);
      chk("ready_acc", 32'(tx_ready), 0);
      lows = 0;
      last_d = 1'b1;
      while (ps2_clk === 1'b0 && lows < INH + 10) begin
         last_d = ps2_data;
         lows++;
         @(negedge clk);
      end
      chk("inhibit_len", lows, INH);
      chk("rts_data", 32'(last_d), 0);
      dev_frame(11, v.ack, rd, ok);
      chk("dev_start", 32'(ok), 1);
      chk("frame_bits", 32'(rd), 32'({1'b1, ~^v.data, v.data, 1'b0}));
      wait_done(d0, 300, n);
      chk("ready_done", 32'(tx_ready), 1);
      repeat (3) @(negedge clk);
      chk("done_pulse", done_cnt - d0, 1);
      chk("err_pulse", err_cnt - e0, 32'(v.err));
      chk("pulse_width", long_cnt - l0, 0);
   endtask
   initial begin
      vec_t vecs[6];
      logic [10:0] rd;
      bit ok;
      int d0, e0, n, base;
      vecs[0] = '{8'hED, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b0};
      vecs[4] = '{8'hA5, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b0, 1'b1};
      repeat (4) @(negedge clk);
      chk("rst_ready", 32'(tx_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(tx_done), 0);
      chk("rst_err", 32'(tx_err), 0);
      chk("rst_clk", 32'(ps2_clk), 1);
      chk("rst_data", 32'(ps2_data), 1);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      d0 = done_cnt;
      @(negedge clk);
      tx_data = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      dev_frame(5, 1'b0, rd, ok);
      chk("mid_dev_start", 32'(ok), 1);
      chk("mid_bits", 32'(rd[4:0]), 32'(5'b11010));
      chk("mid_data_low", 32'(ps2_data), 0);
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_clk", 32'(ps2_clk), 1);
      chk("mid_rst_data", 32'(ps2_data), 1);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ready", 32'(tx_ready), 1);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid_no_done", done_cnt - d0, 0);
      run_vec('{8'hEE, 1'b1, 1'b0});
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      tx_data = 8'hF4;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hF5;
      chk("b2b_busy1", 32'(busy), 1);
      base = rdy_hi;
      dev_frame(11, 1'b1, rd, ok);
      chk("b2b_bits1", 32'(rd), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
      wait_done(d0, 300, n);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("b2b_busy2", 32'(busy), 1);
      dev_frame(11, 1'b1, rd, ok);
      chk("b2b_bits2", 32'(rd), 32'({1'b1, 1'b1, 8'hF5, 1'b0}));
      wait_done(d0 + 1, 300, n);
      chk("b2b_ready_gap", rdy_hi - base, 2);
      repeat (3) @(negedge clk);
      chk("b2b_done", done_cnt - d0, 2);
      chk("b2b_err", err_cnt - e0, 0);
`ifdef PS2_TX_TIMEOUT_EN
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      tx_data = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_done(d0, INH + TMO + 50, n);
      chk("tmo_latency", 32'(n >= INH + TMO - 2 && n <= INH + TMO + 2), 1);
      chk("tmo_err", err_cnt - e0, 1);
      chk("tmo_clk", 32'(ps2_clk), 1);
      chk("tmo_data", 32'(ps2_data), 1);
      chk("tmo_ready", 32'(tx_ready), 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
